// File: rtl/snn_pkg.sv
// Shared definitions for the spiking-network receive path: decoder FSM states,
// default counter width and the all-ones pattern used for saturation limits.
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        COUNT,
        HOLD
    } snn_state_t;

    localparam int          CNT_W_DEFAULT = 8;
    localparam logic [31:0] SAT_ALL_ONES  = 32'hFFFF_FFFF;

endpackage

// File: rtl/snn_sat_counter.sv
// Saturating up-counter with synchronous clear and a sticky overflow flag.
// next_count/next_sat expose the post-increment value so callers can capture it in the same cycle.
module snn_sat_counter
    import snn_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         sat,
    output logic [W-1:0] next_count,
    output logic         next_sat
);

    localparam logic [W-1:0] MAX_CNT = SAT_ALL_ONES[W-1:0];

    logic at_max;

    // The flag marks an increment that was refused at the limit, not merely reaching it.
    always_comb begin
        at_max     = (count == MAX_CNT);
        next_count = (inc && !at_max) ? count + W'(1) : count;
        next_sat   = sat | (inc && at_max);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clear) begin
            count <= '0;
            sat   <= 1'b0;
        end else begin
            count <= next_count;
            sat   <= next_sat;
        end
    end

endmodule

// File: rtl/spike_rate_decoder.sv
// Converts a spike train into windowed spike counts delivered over a valid/ready port.
// Define SPIKE_ISI_EN to add the minimum inter-spike-interval output isi_min.
module spike_rate_decoder
    import snn_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             spike_in,
    input  logic [CNT_W-1:0] window_len,
    input  logic             rate_ready,
    output logic             rate_valid,
    output logic [CNT_W-1:0] rate_count,
    output logic             rate_sat,
    output logic             busy
`ifdef SPIKE_ISI_EN
    ,
    output logic [CNT_W-1:0] isi_min
`endif
);

    snn_state_t       state;
    logic [CNT_W-1:0] win_cnt;

    logic             win_end;
    logic             slot_free;
    logic             can_start;
    logic             load_new;
    logic             load_held;
    logic             start_window;
    logic             spike_inc;

    logic [CNT_W-1:0] acc_count;
    logic [CNT_W-1:0] acc_next;
    logic             acc_sat;
    logic             acc_next_sat;

    // load_new takes the result straight from the counter's next value so the
    // last window cycle's spike is included; load_held drains a result parked in HOLD.
    always_comb begin
        win_end      = (state == COUNT) && (win_cnt == CNT_W'(1));
        slot_free    = !rate_valid || rate_ready;
        can_start    = enable && (window_len != '0);
        load_new     = win_end && slot_free;
        load_held    = (state == HOLD) && rate_ready;
        start_window = can_start && ((state == IDLE) || load_new || load_held);
        spike_inc    = (state == COUNT) && spike_in;
    end

    snn_sat_counter #(
        .W(CNT_W)
    ) u_spike_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_window),
        .inc       (spike_inc),
        .count     (acc_count),
        .sat       (acc_sat),
        .next_count(acc_next),
        .next_sat  (acc_next_sat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            win_cnt <= '0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (can_start) begin
                        state   <= COUNT;
                        win_cnt <= window_len;
                        busy    <= 1'b1;
                    end
                end
                COUNT: begin
                    if (win_end) begin
                        if (!slot_free) begin
                            state <= HOLD;
                        end else if (can_start) begin
                            win_cnt <= window_len;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        win_cnt <= win_cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (rate_ready) begin
                        if (can_start) begin
                            state   <= COUNT;
                            win_cnt <= window_len;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rate_valid <= 1'b0;
            rate_count <= '0;
            rate_sat   <= 1'b0;
        end else if (load_new) begin
            rate_valid <= 1'b1;
            rate_count <= acc_next;
            rate_sat   <= acc_next_sat;
        end else if (load_held) begin
            rate_valid <= 1'b1;
            rate_count <= acc_count;
            rate_sat   <= acc_sat;
        end else if (rate_ready) begin
            rate_valid <= 1'b0;
        end
    end

`ifdef SPIKE_ISI_EN
    localparam logic [CNT_W-1:0] ISI_NONE = SAT_ALL_ONES[CNT_W-1:0];

    logic [CNT_W-1:0] gap_count;
    logic [CNT_W-1:0] gap_next;
    logic             gap_sat;
    logic             gap_next_sat;
    logic             gap_unused;
    logic             seen_spike;
    logic [CNT_W-1:0] isi_acc;
    logic [CNT_W-1:0] isi_acc_next;

    // gap_count holds cycles since the last spike minus one, so gap_next is the interval itself.
    snn_sat_counter #(
        .W(CNT_W)
    ) u_gap (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (start_window || spike_inc),
        .inc       (state == COUNT),
        .count     (gap_count),
        .sat       (gap_sat),
        .next_count(gap_next),
        .next_sat  (gap_next_sat)
    );

    assign gap_unused = &{1'b0, gap_count, gap_sat, gap_next_sat};

    always_comb begin
        isi_acc_next = isi_acc;
        if (spike_inc && seen_spike && (gap_next < isi_acc)) begin
            isi_acc_next = gap_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seen_spike <= 1'b0;
            isi_acc    <= ISI_NONE;
        end else if (start_window) begin
            seen_spike <= 1'b0;
            isi_acc    <= ISI_NONE;
        end else begin
            seen_spike <= seen_spike | spike_inc;
            isi_acc    <= isi_acc_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            isi_min <= ISI_NONE;
        end else if (load_new) begin
            isi_min <= isi_acc_next;
        end else if (load_held) begin
            isi_min <= isi_acc;
        end
    end
`endif

    hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (rate_valid && !rate_ready) |=> (rate_valid && $stable(rate_count) && $stable(rate_sat)));

    busy_tracks_state: assert property (@(posedge clk) busy == (state != IDLE));

endmodule

// File: tb/tb_spike_rate_decoder.sv
// Scoreboard bench for spike_rate_decoder: directed windows push expected results,
// a negedge monitor pops and compares each accepted result.
module tb_spike_rate_decoder;

    typedef struct packed {
        logic [7:0] cnt;
        logic       sat;
        logic [7:0] isi;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic       spike_in;
    logic [7:0] window_len;
    logic       rate_ready;
    logic       rate_valid;
    logic [7:0] rate_count;
    logic       rate_sat;
    logic       busy;
`ifdef SPIKE_ISI_EN
    logic [7:0] isi_min;
`endif

    exp_t expq[$];
    int   errors = 0;
    int   checks = 0;

    spike_rate_decoder #(
        .CNT_W(8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .spike_in  (spike_in),
        .window_len(window_len),
        .rate_ready(rate_ready),
        .rate_valid(rate_valid),
        .rate_count(rate_count),
        .rate_sat  (rate_sat),
        .busy      (busy)
`ifdef SPIKE_ISI_EN
        ,
        .isi_min   (isi_min)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one spike bit per cycle; bit k of mask is the spike for cycle k.
    task automatic applyStimulus(input int cycles, input logic [31:0] mask, input bit all_spikes);
        for (int k = 0; k < cycles; k++) begin
            spike_in = all_spikes | ((k < 32) ? mask[k] : 1'b0);
            step();
        end
        spike_in = 1'b0;
    endtask

    task automatic pushExpect(input logic [7:0] cnt, input logic sat, input logic [7:0] isi);
        exp_t e;
        e.cnt = cnt;
        e.sat = sat;
        e.isi = isi;
        expq.push_back(e);
    endtask

    // Monitor: every accepted result must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && rate_valid && rate_ready) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_result", rate_count, 32'hDEAD);
            end else begin
                exp_t e;
                e = expq.pop_front();
                checkOutput("rate_count", rate_count, e.cnt);
                checkOutput("rate_sat", rate_sat, e.sat);
`ifdef SPIKE_ISI_EN
                checkOutput("isi_min", isi_min, e.isi);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b0;
        spike_in   = 1'b0;
        window_len = 8'd0;
        rate_ready = 1'b0;
        repeat (2) step();

        checkOutput("reset_valid", rate_valid, 0);
        checkOutput("reset_count", rate_count, 0);
        checkOutput("reset_sat", rate_sat, 0);
        checkOutput("reset_busy", busy, 0);
`ifdef SPIKE_ISI_EN
        checkOutput("reset_isi", isi_min, 8'hFF);
`endif
        rst_n = 1'b1;
        step();

        // window_len of zero never starts a window
        enable = 1'b1;
        repeat (3) step();
        checkOutput("zero_len_busy", busy, 0);
        checkOutput("zero_len_valid", rate_valid, 0);

        // Spikes on cycles 0,3,9 of a 10-cycle window
        $display("[TB] test 1: basic window");
        window_len = 8'd10;
        rate_ready = 1'b1;
        step();
        pushExpect(8'd3, 1'b0, 8'd3);
        applyStimulus(9, 32'h0000_0009, 1'b0);
        checkOutput("t1_valid_before_end", rate_valid, 0);
        applyStimulus(1, 32'h0000_0001, 1'b0);
        checkOutput("t1_valid_latency", rate_valid, 1);
        checkOutput("t1_back_to_back_busy", busy, 1);
        enable = 1'b0;
        step();
        checkOutput("t1_idle_busy", busy, 0);
        checkOutput("t1_valid_dropped", rate_valid, 0);

        $display("[TB] test 2: continuous spikes");
        window_len = 8'd4;
        enable     = 1'b1;
        step();
        pushExpect(8'd4, 1'b0, 8'd1);
        applyStimulus(4, 32'h0, 1'b1);
        enable = 1'b0;
        step();
        window_len = 8'd255;
        enable     = 1'b1;
        step();
        pushExpect(8'd255, 1'b0, 8'd1);
        applyStimulus(255, 32'h0, 1'b1);
        enable = 1'b0;
        step();

        $display("[TB] test 3: backpressure and HOLD");
        rate_ready = 1'b0;
        window_len = 8'd5;
        enable     = 1'b1;
        step();
        pushExpect(8'd2, 1'b0, 8'd2);
        applyStimulus(5, 32'h0000_0005, 1'b0);
        checkOutput("t3_first_valid", rate_valid, 1);
        pushExpect(8'd3, 1'b0, 8'd1);
        applyStimulus(5, 32'h0000_001A, 1'b0);
        checkOutput("t3_hold_busy", busy, 1);
        checkOutput("t3_hold_count", rate_count, 2);
        spike_in = 1'b1;
        repeat (3) step();
        spike_in = 1'b0;
        checkOutput("t3_hold_valid_stable", rate_valid, 1);
        checkOutput("t3_hold_count_stable", rate_count, 2);
        enable     = 1'b0;
        rate_ready = 1'b1;
        step();
        rate_ready = 1'b0;
        checkOutput("t3_second_loaded", rate_count, 3);
        checkOutput("t3_second_valid", rate_valid, 1);
        checkOutput("t3_idle_after_hold", busy, 0);
        step();
        rate_ready = 1'b1;
        step();
        step();
        checkOutput("t3_drained", rate_valid, 0);

        $display("[TB] test 4: abort mid-window");
        window_len = 8'd8;
        enable     = 1'b1;
        step();
        applyStimulus(4, 32'h0000_0005, 1'b0);
        enable = 1'b0;
        step();
        checkOutput("t4_abort_busy", busy, 0);
        checkOutput("t4_abort_valid", rate_valid, 0);
        repeat (10) step();
        checkOutput("t4_no_result", rate_valid, 0);

        $display("[TB] test 5: asynchronous reset");
        window_len = 8'd10;
        enable     = 1'b1;
        step();
        applyStimulus(3, 32'h0000_0007, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_count_rst_busy", busy, 0);
        checkOutput("t5_count_rst_valid", rate_valid, 0);
        enable = 1'b0;
        step();
        rst_n      = 1'b1;
        rate_ready = 1'b0;
        window_len = 8'd3;
        enable     = 1'b1;
        step();
        applyStimulus(3, 32'h0000_0003, 1'b0);
        applyStimulus(3, 32'h0000_0001, 1'b0);
        checkOutput("t5_pre_hold_busy", busy, 1);
        checkOutput("t5_pre_hold_count", rate_count, 2);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t5_hold_rst_valid", rate_valid, 0);
        checkOutput("t5_hold_rst_count", rate_count, 0);
        checkOutput("t5_hold_rst_sat", rate_sat, 0);
        checkOutput("t5_hold_rst_busy", busy, 0);
`ifdef SPIKE_ISI_EN
        checkOutput("t5_hold_rst_isi", isi_min, 8'hFF);
`endif
        enable = 1'b0;
        step();
        rst_n      = 1'b1;
        rate_ready = 1'b1;
        step();

        $display("[TB] test 6: inter-spike interval windows");
        window_len = 8'd20;
        enable     = 1'b1;
        step();
        pushExpect(8'd4, 1'b0, 8'd1);
        applyStimulus(20, 32'h0000_8064, 1'b0);
        pushExpect(8'd1, 1'b0, 8'hFF);
        applyStimulus(20, 32'h0000_0080, 1'b0);
        enable = 1'b0;
        repeat (3) step();

        checkOutput("queue_empty", expq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
